// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and frame geometry.
// Used by the FIFO-fed transmitter now and by the receiver later.
package uart_pkg;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_FRAME_BITS           = 10;
  localparam int UART_CLKS_PER_BIT_DEFAULT = 16;

  // Three bits wide so the unused encodings exist and can be recovered from.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3
  } uart_state_t;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Bundle between the FIFO read port, the enable source and the UART transmitter.
// The transmitter uses the slave side; the FIFO and its controller use the master side.
interface fifo_uart_tx_if
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_BITS
);

  logic              en;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_rd;
  logic              tx;
  logic              busy;
  logic              byte_done;

  modport master (
    output en, fifo_empty, fifo_data,
    input  fifo_rd, tx, busy, byte_done
  );

  modport slave (
    input  en, fifo_empty, fifo_data,
    output fifo_rd, tx, busy, byte_done
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: bit_tick marks the last cycle of each bit, pre_tick the one before.
// Held at zero while clear is high so the first bit period starts cleanly.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_tick,
  output logic pre_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count <= '0;
    end else if (count == CNT_LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign bit_tick = (count == CNT_LAST);
  assign pre_tick = (count == CNT_PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO read-side consumer: pops one byte at a time and sends it as a UART 8N1 frame.
// All interface outputs come straight from flops.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int DATA_W       = UART_DATA_BITS
) (
  input  logic              clk,
  input  logic              rst_n,
  fifo_uart_tx_if.slave     bus
);

  uart_state_t       state;
  logic [DATA_W-1:0] shift_reg;
  logic [2:0]        bit_idx;
  logic              tx_q;
  logic              fifo_rd_q;
  logic              busy_q;
  logic              byte_done_q;
  logic              bit_tick;
  logic              pre_tick;
  logic              baud_clear;

  // Baud counter restarts on every frame because it is held clear through IDLE.
  assign baud_clear = (state == ST_IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (baud_clear),
    .bit_tick (bit_tick),
    .pre_tick (pre_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      shift_reg   <= '0;
      bit_idx     <= '0;
      tx_q        <= 1'b1;
      fifo_rd_q   <= 1'b0;
      busy_q      <= 1'b0;
      byte_done_q <= 1'b0;
    end else begin
      fifo_rd_q   <= 1'b0;
      byte_done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (bus.en && !bus.fifo_empty) begin
            shift_reg <= bus.fifo_data;
            fifo_rd_q <= 1'b1;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            bit_idx   <= '0;
            state     <= ST_START;
          end
        end
        ST_START: begin
          if (bit_tick) begin
            tx_q      <= shift_reg[0];
            shift_reg <= {1'b0, shift_reg[DATA_W-1:1]};
            state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            if (bit_idx == 3'd7) begin
              tx_q  <= 1'b1;
              state <= ST_STOP;
            end else begin
              tx_q      <= shift_reg[0];
              shift_reg <= {1'b0, shift_reg[DATA_W-1:1]};
              bit_idx   <= bit_idx + 1'b1;
            end
          end
        end
        ST_STOP: begin
          // pre_tick lands the flag exactly in the final stop-bit cycle.
          if (pre_tick) begin
            byte_done_q <= 1'b1;
          end
          if (bit_tick) begin
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.tx        = tx_q;
  assign bus.fifo_rd   = fifo_rd_q;
  assign bus.busy      = busy_q;
  assign bus.byte_done = byte_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: fall-through FIFO model with a registered empty flag feeds
// the DUT; frames are checked cycle by cycle against the 8N1 waveform of each byte.
module tb_fifo_uart_tx;
  import uart_pkg::*;

  localparam int CPB       = 4;
  localparam int FRAME_CYC = 10 * CPB;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_uart_tx_if #(.DATA_W(8)) bus ();

  fifo_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .DATA_W       (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total     = 0;
  int bad       = 0;
  int pop_count = 0;

  logic [7:0] mem [64];
  int         wr_ptr    = 0;
  int         rd_ptr    = 0;
  logic       flush_req = 1'b0;
  logic       empty_q   = 1'b1;

  assign bus.fifo_empty = empty_q;
  assign bus.fifo_data  = mem[rd_ptr[5:0]];

  task automatic check_output(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check_output(name, int'(act), int'(exp));
  endtask

  // FIFO model: pop on the clock edge that sees fifo_rd, empty flag registered.
  always @(posedge clk) begin
    if (flush_req) begin
      rd_ptr  <= wr_ptr;
      empty_q <= 1'b1;
    end else if (bus.fifo_rd && rd_ptr != wr_ptr) begin
      rd_ptr  <= rd_ptr + 1;
      empty_q <= ((rd_ptr + 1) == wr_ptr);
    end else begin
      empty_q <= (rd_ptr == wr_ptr);
    end
  end

  always @(negedge clk) begin
    if (bus.fifo_rd) begin
      pop_count++;
      check_bit("pop_when_empty", rd_ptr != wr_ptr, 1'b1);
    end
  end

  task automatic apply_stimulus(input logic [7:0] d);
    mem[wr_ptr[5:0]] = d;
    wr_ptr++;
  endtask

  task automatic flush_fifo();
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    @(negedge clk);
  endtask

  // Enter and leave at a falling edge. Cycle k=1 is the first cycle after the start edge.
  task automatic check_frame(input logic [9:0] frame, input int max_wait, input int drop_at,
                             input int last_k, input string name);
    int   w;
    logic exp_tx;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!bus.fifo_rd && w < max_wait);
    if (!bus.fifo_rd) begin
      check_bit({name, "_start_timeout"}, 1'b0, 1'b1);
      return;
    end
    for (int k = 1; k <= last_k; k++) begin
      if (k > 1) @(negedge clk);
      exp_tx = frame[4'((k - 1) / CPB)];
      check_bit({name, "_tx"}, bus.tx, exp_tx);
      check_bit({name, "_busy"}, bus.busy, 1'b1);
      check_bit({name, "_rd"}, bus.fifo_rd, k == 1);
      check_bit({name, "_done"}, bus.byte_done, k == FRAME_CYC);
      if (k == drop_at) bus.en = 1'b0;
    end
    if (last_k == FRAME_CYC) begin
      @(negedge clk);
      check_bit({name, "_gap_tx"}, bus.tx, 1'b1);
      check_bit({name, "_gap_busy"}, bus.busy, 1'b0);
      check_bit({name, "_gap_done"}, bus.byte_done, 1'b0);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int         p0;
    int         done;
    logic [7:0] d;
    logic [7:0] exp_q[$];

    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'h3C, 10'b1001111000};
    vecs[4] = '{8'h81, 10'b1100000010};

    // Reset held with a non-empty FIFO and enable high.
    bus.en = 1'b1;
    apply_stimulus(8'hA5);
    repeat (3) @(negedge clk);
    check_bit("rst_tx", bus.tx, 1'b1);
    check_bit("rst_busy", bus.busy, 1'b0);
    check_bit("rst_rd", bus.fifo_rd, 1'b0);
    check_bit("rst_done", bus.byte_done, 1'b0);
    bus.en = 1'b0;
    flush_fifo();
    rst_n = 1'b1;
    @(negedge clk);

    bus.en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      p0 = pop_count;
      apply_stimulus(vecs[i].data);
      check_frame(vecs[i].frame, 20, 0, FRAME_CYC, "table");
      check_output("table_pops", pop_count - p0, 1);
    end

    // Back-to-back: the second start must follow the first after exactly 41 cycles.
    p0 = pop_count;
    apply_stimulus(8'h00);
    apply_stimulus(8'hFF);
    check_frame(10'b1000000000, 20, 0, FRAME_CYC, "b2b_first");
    check_frame(10'b1111111110, 1, 0, FRAME_CYC, "b2b_second");
    repeat (20) @(negedge clk);
    check_bit("b2b_idle_tx", bus.tx, 1'b1);
    check_output("b2b_pops", pop_count - p0, 2);

    // Enable low blocks pops; dropping enable mid-frame finishes only that frame.
    bus.en = 1'b0;
    apply_stimulus(8'h5A);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      check_bit("en_low_rd", bus.fifo_rd, 1'b0);
      check_bit("en_low_tx", bus.tx, 1'b1);
    end
    apply_stimulus(8'hC3);
    p0 = pop_count;
    bus.en = 1'b1;
    check_frame(10'b1010110100, 20, 14, FRAME_CYC, "en_drop");
    repeat (60) @(negedge clk);
    check_output("en_drop_pops", pop_count - p0, 1);
    check_bit("en_drop_idle_tx", bus.tx, 1'b1);
    check_bit("en_drop_idle_busy", bus.busy, 1'b0);
    flush_fifo();
    bus.en = 1'b1;

    // Reset pulse during data bit 3, then a clean frame of the new head byte.
    p0 = pop_count;
    apply_stimulus(8'h3C);
    apply_stimulus(8'h96);
    check_frame(10'b1001111000, 20, 0, 18, "abort");
    rst_n = 1'b0;
    @(negedge clk);
    check_bit("abort_tx", bus.tx, 1'b1);
    check_bit("abort_busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    check_frame(10'b1100101100, 20, 0, FRAME_CYC, "after_abort");
    check_output("abort_pops", pop_count - p0, 2);

    // Empty FIFO with enable high: nothing happens.
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      check_bit("empty_rd", bus.fifo_rd, 1'b0);
      check_bit("empty_tx", bus.tx, 1'b1);
      check_bit("empty_busy", bus.busy, 1'b0);
    end

    // Random bytes in random bursts against a queue of expected payloads.
    done = 0;
    while (done < 24) begin
      if (exp_q.size() == 0 || $urandom_range(0, 2) == 0) begin
        for (int n = $urandom_range(1, 3); n > 0; n--) begin
          d = 8'($urandom);
          apply_stimulus(d);
          exp_q.push_back(d);
        end
      end
      d = exp_q.pop_front();
      check_frame({1'b1, d, 1'b0}, 20, 0, FRAME_CYC, "rand");
      done++;
    end
    bus.en = 1'b0;
    flush_fifo();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
